// File: rtl/phy_rx.sv
// phy_rx: serial byte-aligning receiver.
// Shifts one bit per clk_32f edge, locks byte alignment on COMMA bytes
// (SEARCH -> SYNC -> ACTIVE), then packs data bytes into four lanes and
// publishes them together. Commas in ACTIVE are idles.
// Optional feature: define PHY_RX_ERR_CNT_EN to add the saturating err_cnt output.
module phy_rx #(
   parameter logic [7:0] COMMA       = 8'hBC,
   parameter int         SYNC_COMMAS = 2
) (
   input  logic       clk_32f,
   input  logic       rst,
   input  logic       serial_in,
   output logic [7:0] out0,
   output logic [7:0] out1,
   output logic [7:0] out2,
   output logic [7:0] out3,
   output logic       valid_out0,
   output logic       valid_out1,
   output logic       valid_out2,
   output logic       valid_out3,
   output logic       active,
   output logic       err
`ifdef PHY_RX_ERR_CNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);

   typedef enum logic [1:0] {SEARCH = 2'd0, SYNC = 2'd1, ACTIVE = 2'd2} state_t;

   localparam logic [7:0] SYNC_N = 8'(SYNC_COMMAS);

   state_t     state_q, state_d;
   logic [7:0] sr_q, sr_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [1:0] lane_q, lane_d;
   logic [7:0] comma_cnt_q, comma_cnt_d;
   logic [7:0] buf0_q, buf0_d, buf1_q, buf1_d, buf2_q, buf2_d, buf3_q, buf3_d;
   logic [7:0] out0_q, out0_d, out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
   logic       valid_q, valid_d;
   logic       publish_q, publish_d;
   logic       active_q, active_d;
   logic       err_q, err_d;
   logic       byte_done, is_comma;

   // Next-state, alignment and lane-packing logic.
   always_comb begin
      state_d     = state_q;
      sr_d        = {sr_q[6:0], serial_in};
      bit_cnt_d   = bit_cnt_q + 3'd1;
      lane_d      = lane_q;
      comma_cnt_d = comma_cnt_q;
      buf0_d      = buf0_q;
      buf1_d      = buf1_q;
      buf2_d      = buf2_q;
      buf3_d      = buf3_q;
      out0_d      = out0_q;
      out1_d      = out1_q;
      out2_d      = out2_q;
      out3_d      = out3_q;
      valid_d     = valid_q;
      publish_d   = 1'b0;
      err_d       = 1'b0;
      // A byte completes on the edge where the counter sits at 7; the
      // completed byte is the value being shifted in this edge.
      byte_done   = (bit_cnt_q == 3'd7);
      is_comma    = (sr_d == COMMA);

      // Group captured last edge is presented one edge after lane 3 completes.
      if (publish_q) begin
         out0_d  = buf0_q;
         out1_d  = buf1_q;
         out2_d  = buf2_q;
         out3_d  = buf3_q;
         valid_d = 1'b1;
      end

      case (state_q)
         SEARCH: begin
            // Commas are checked at every bit offset; a hit fixes the boundary.
            if (is_comma) begin
               bit_cnt_d   = 3'd0;
               comma_cnt_d = 8'd1;
               state_d     = SYNC;
            end
         end
         SYNC: begin
            if (byte_done) begin
               if (is_comma) begin
                  comma_cnt_d = comma_cnt_q + 8'd1;
                  if (comma_cnt_d >= SYNC_N) begin
                     state_d = ACTIVE;
                     lane_d  = 2'd0;
                  end
               end else begin
                  state_d     = SEARCH;
                  comma_cnt_d = 8'd0;
                  err_d       = 1'b1;
               end
            end
         end
         ACTIVE: begin
            // Off-boundary comma patterns are ignored; only byte_done matters.
            if (byte_done) begin
               if (is_comma) begin
                  err_d   = (lane_q != 2'd0);
                  lane_d  = 2'd0;
                  valid_d = 1'b0;
               end else begin
                  case (lane_q)
                     2'd0: buf0_d = sr_d;
                     2'd1: buf1_d = sr_d;
                     2'd2: buf2_d = sr_d;
                     default: begin
                        buf3_d    = sr_d;
                        publish_d = 1'b1;
                     end
                  endcase
                  lane_d = lane_q + 2'd1;
               end
            end
         end
         default: state_d = SEARCH;
      endcase

      active_d = (state_d == ACTIVE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_32f) begin
      if (rst) begin
         state_q     <= SEARCH;
         sr_q        <= 8'd0;
         bit_cnt_q   <= 3'd0;
         lane_q      <= 2'd0;
         comma_cnt_q <= 8'd0;
         buf0_q      <= 8'd0;
         buf1_q      <= 8'd0;
         buf2_q      <= 8'd0;
         buf3_q      <= 8'd0;
         out0_q      <= 8'd0;
         out1_q      <= 8'd0;
         out2_q      <= 8'd0;
         out3_q      <= 8'd0;
         valid_q     <= 1'b0;
         publish_q   <= 1'b0;
         active_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         lane_q      <= lane_d;
         comma_cnt_q <= comma_cnt_d;
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
         buf2_q      <= buf2_d;
         buf3_q      <= buf3_d;
         out0_q      <= out0_d;
         out1_q      <= out1_d;
         out2_q      <= out2_d;
         out3_q      <= out3_d;
         valid_q     <= valid_d;
         publish_q   <= publish_d;
         active_q    <= active_d;
         err_q       <= err_d;
      end
   end

`ifdef PHY_RX_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Saturating count of err pulses.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   // Error counter register.
   always_ff @(posedge clk_32f) begin
      if (rst) err_cnt_q <= 8'd0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif

   assign out0       = out0_q;
   assign out1       = out1_q;
   assign out2       = out2_q;
   assign out3       = out3_q;
   assign valid_out0 = valid_q;
   assign valid_out1 = valid_q;
   assign valid_out2 = valid_q;
   assign valid_out3 = valid_q;
   assign active     = active_q;
   assign err        = err_q;

endmodule

// File: tb/tb_phy_rx.sv
// Scoreboard bench for phy_rx: stimulus pushes expected output events
// {err, valid mask, out0..out3}; a monitor pops one per observed event.
module tb_phy_rx;

   logic       clk_32f = 1'b0;
   logic       rst = 1'b1;
   logic       serial_in = 1'b0;
   logic [7:0] out0, out1, out2, out3;
   logic       valid_out0, valid_out1, valid_out2, valid_out3;
   logic       active, err;
`ifdef PHY_RX_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   int checks = 0;
   int failures = 0;
   logic [36:0] exp_q[$];
   logic        rst_at_edge = 1'b1;
   logic [3:0]  prev_v = 4'h0;
   logic [31:0] prev_d = 32'h0;

   phy_rx dut (
      .clk_32f(clk_32f), .rst(rst), .serial_in(serial_in),
      .out0(out0), .out1(out1), .out2(out2), .out3(out3),
      .valid_out0(valid_out0), .valid_out1(valid_out1),
      .valid_out2(valid_out2), .valid_out3(valid_out3),
      .active(active), .err(err)
`ifdef PHY_RX_ERR_CNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   always #5 clk_32f = ~clk_32f;

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", nm, act, expv);
      end
   endtask

   task automatic push(input logic e, input logic [3:0] v, input logic [31:0] d);
      exp_q.push_back({e, v, d});
   endtask

   task automatic send_bit(input logic b);
      serial_in = b;
      @(posedge clk_32f);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      serial_in = 1'b0;
      repeat (4) @(posedge clk_32f);
      #1;
      chk("reset_outs", {8'h0, out0, out1, out2, out3}, 40'h0);
      chk("reset_flags", {34'h0, valid_out0, valid_out1, valid_out2, valid_out3, active, err}, 40'h0);
      rst = 1'b0;
   endtask

   // Track whether rst was sampled at the most recent edge.
   always @(posedge clk_32f) rst_at_edge <= rst;

   // Monitor: an event is an err pulse, a valid change, or new published data.
   always @(negedge clk_32f) begin
      logic [3:0]  vm;
      logic [31:0] dd;
      logic [36:0] e;
      vm = {valid_out0, valid_out1, valid_out2, valid_out3};
      dd = {out0, out1, out2, out3};
      if (!rst_at_edge && (err || vm != prev_v || (vm == 4'hF && dd != prev_d))) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event got err=%b valid=%h data=%h expected none", err, vm, dd);
         end else begin
            e = exp_q.pop_front();
            $display("event err=%b valid=%h data=%h", err, vm, dd);
            chk("event", {3'b0, err, vm, dd}, {3'b0, e});
         end
      end
      prev_v = vm;
      prev_d = dd;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;

      // Basic lock and group publish, then partial group aborted by comma.
      do_reset();
      push(1'b0, 4'hF, 32'hAABBCCDD);
      send_byte(8'hBC);
      chk("active_after_1st_comma", {39'h0, active}, 40'h0);
      send_byte(8'hBC);
      chk("active_after_2nd_comma", {39'h0, active}, 40'h1);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      chk("latency_pre", {36'h0, valid_out0, valid_out1, valid_out2, valid_out3}, 40'h0);
      b = 8'h11;
      send_bit(b[7]);
      chk("latency_post", {36'h0, valid_out0, valid_out1, valid_out2, valid_out3}, 40'hF);
      chk("latency_out3", {32'h0, out3}, 40'hDD);
      for (int i = 6; i >= 0; i--) send_bit(b[i]);
      push(1'b1, 4'h0, 32'hAABBCCDD);
      send_byte(8'h22); send_byte(8'hBC);
      chk("active_after_abort", {39'h0, active}, 40'h1);

      // Alignment at a 3-bit offset, then an idle.
      do_reset();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      push(1'b0, 4'hF, 32'hFF00FF00);
      send_byte(8'hBC); send_byte(8'hBC);
      chk("active_offset3", {39'h0, active}, 40'h1);
      send_byte(8'hFF); send_byte(8'h00); send_byte(8'hFF); send_byte(8'h00);
      push(1'b0, 4'h0, 32'hFF00FF00);
      send_byte(8'hBC);

      // Idle after a full group: valids drop, data held, no err.
      do_reset();
      push(1'b0, 4'hF, 32'h11223344);
      push(1'b0, 4'h0, 32'h11223344);
      send_byte(8'hBC); send_byte(8'hBC);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'hBC);
      chk("active_after_idle", {39'h0, active}, 40'h1);

      // SYNC failure, repeated 12 times.
      do_reset();
      for (int k = 0; k < 12; k++) begin
         push(1'b1, 4'h0, 32'h0);
         send_byte(8'hBC); send_byte(8'h5A);
         chk("active_sync_fail", {39'h0, active}, 40'h0);
      end
      @(posedge clk_32f); #1;
`ifdef PHY_RX_ERR_CNT_EN
      chk("err_cnt_12", {32'h0, err_cnt}, 40'd12);
`endif

      // Reset mid-group, then realign from scratch.
      do_reset();
      push(1'b0, 4'hF, 32'h11223344);
      send_byte(8'hBC); send_byte(8'hBC);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55);
      b = 8'h66;
      for (int i = 7; i >= 4; i--) send_bit(b[i]);
      rst = 1'b1;
      @(posedge clk_32f); #1;
      chk("midrst_outs", {8'h0, out0, out1, out2, out3}, 40'h0);
      chk("midrst_flags", {34'h0, valid_out0, valid_out1, valid_out2, valid_out3, active, err}, 40'h0);
`ifdef PHY_RX_ERR_CNT_EN
      chk("midrst_err_cnt", {32'h0, err_cnt}, 40'h0);
`endif
      rst = 1'b0;
      push(1'b0, 4'hF, 32'hA1B2C3D4);
      send_byte(8'hBC);
      chk("realign_not_yet", {39'h0, active}, 40'h0);
      send_byte(8'hBC);
      chk("realign_active", {39'h0, active}, 40'h1);
      send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);

      serial_in = 1'b0;
      repeat (20) @(posedge clk_32f);
      #1;
      chk("queue_drained", 40'(exp_q.size()), 40'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/phy_rx.md
PHY_RX -- requirements
Module: phy_rx

Interface
REQ-001 SHALL have port clk_32f, input, 1 bit: bit clock, one serial bit per rising edge; the only clock.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port serial_in, input, 1 bit: serial stream, MSB of each byte first.
REQ-004 SHALL have ports out0, out1, out2, out3, output, 8 bits each: recovered lane bytes.
REQ-005 SHALL have ports valid_out0, valid_out1, valid_out2, valid_out3, output, 1 bit each: lane byte valid.
REQ-006 SHALL have port active, output, 1 bit: byte alignment achieved (state ACTIVE).
REQ-007 SHALL have port err, output, 1 bit: one-cycle pulse on a framing error.
REQ-008 SHALL have parameter COMMA, default 8'hBC: idle/comma byte.
REQ-009 SHALL have parameter SYNC_COMMAS, default 2: consecutive aligned commas required to enter ACTIVE.

Function
REQ-010 SHALL shift serial_in into an 8-bit register each edge: sr <= {sr[6:0], serial_in}.
REQ-011 SHALL implement states SEARCH, SYNC, ACTIVE; rst forces SEARCH.
REQ-012 In SEARCH, the edge on which sr becomes COMMA SHALL define the byte boundary: bit counter cleared, comma count = 1, go to SYNC; comma checked at every bit offset.
REQ-013 After alignment, a byte SHALL complete every 8th edge after the boundary-defining edge; bit counter wraps 7->0.
REQ-014 In SYNC, a completed byte equal to COMMA SHALL increment comma count; on reaching SYNC_COMMAS, go to ACTIVE.
REQ-015 In SYNC, a completed non-COMMA byte SHALL return to SEARCH, pulse err, and leave outputs unchanged.
REQ-016 In ACTIVE, a completed COMMA byte SHALL be idle: clear lane counter, generate no data.
REQ-017 In ACTIVE, a completed non-COMMA byte SHALL be stored in the lane given by a 2-bit lane counter (0->1->2->3), then the counter increments.
REQ-018 When the lane-3 byte completes, out0..out3 SHALL update together on the next edge (1-cycle latency), all valid_outN = 1.
REQ-019 Outputs and valids SHALL hold until the next group publish or an idle.
REQ-020 A COMMA completing in ACTIVE while the lane counter is nonzero SHALL discard the partial group, pulse err, and drop all valid_outN to 0.
REQ-021 A COMMA completing in ACTIVE with the lane counter at zero SHALL drop all valid_outN to 0 and leave outN holding their last values.
REQ-022 ACTIVE SHALL be left only by rst; sr matching COMMA at a non-boundary offset in ACTIVE SHALL be ignored.
REQ-023 active SHALL be 1 exactly while the state is ACTIVE, registered.

Reset
REQ-024 With rst high at a clk_32f edge: state SEARCH; sr, bit counter, lane counter, comma count = 0.
REQ-025 With rst high at a clk_32f edge: out0..out3 = 8'h00; valid_out0..3, active, err = 0.
REQ-026 rst asserted mid-group SHALL discard all partial data; after release, alignment restarts from SEARCH.

Configuration
REQ-027 With macro PHY_RX_ERR_CNT_EN defined, SHALL add output err_cnt (8 bits): increments on each err pulse, saturates at 8'hFF, cleared by rst.
REQ-028 Without PHY_RX_ERR_CNT_EN, port err_cnt and its counter SHALL NOT exist; all other behaviour is identical.

Verification
REQ-029 rst 4 cycles, then send BC,BC,AA,BB,CC,DD -> active=1 after second BC completes; out0..3 = AA,BB,CC,DD, valid all 1, one edge after DD completes.
REQ-030 Send 3 junk bits, then BC,BC,FF,00,FF,00 -> alignment found at offset 3; outputs FF,00,FF,00.
REQ-031 Aligned, send 11,22,BC -> err pulse one cycle; valid_out all 0; out0..3 unchanged from previous group.
REQ-032 SEARCH, send BC,5A -> returns to SEARCH, err=1, active stays 0.
REQ-033 Send BC,BC,11,22,33,44,BC -> after the trailing BC: valids 0, outputs stay 11,22,33,44, err not asserted.
REQ-034 Send 12 or more errors with PHY_RX_ERR_CNT_EN defined -> err_cnt tracks the count; assert rst mid-group -> all outputs 0 and state SEARCH next cycle.
